// File: rtl/fp_mul_arbiter.sv
// Round-robin arbiter that time-shares one combinational single-precision multiplier
// among N requesters, with a one-deep issue stage and a per-requester response slot.

module fp_multiplier (
  input  logic [31:0] num1,
  input  logic [31:0] num2,
  output logic [31:0] final_product
);

  logic        sign;
  logic [7:0]  ea, eb;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [47:0] prod;
  logic [22:0] mant;
  logic        guard, sticky, round_up;
  logic [23:0] mant_r;
  logic [9:0]  exp_sum;

  always_comb begin
    sign   = num1[31] ^ num2[31];
    ea     = num1[30:23];
    eb     = num2[30:23];
    a_nan  = (ea == 8'hFF) && (num1[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (num2[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (num1[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (num2[22:0] == 23'd0);
    // Subnormal operands are flushed to zero.
    a_zero = (ea == 8'h00);
    b_zero = (eb == 8'h00);
    prod   = {24'd0, 1'b1, num1[22:0]} * {24'd0, 1'b1, num2[22:0]};

    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    // Round to nearest, ties to even; a mantissa carry-out bumps the exponent.
    round_up = guard & (sticky | mant[0]);
    mant_r   = {1'b0, mant} + {23'd0, round_up};
    exp_sum  = {2'b00, ea} + {2'b00, eb} + {9'd0, prod[47]} + {9'd0, mant_r[23]};

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      final_product = 32'h7FC0_0000;
    end else if (a_inf || b_inf) begin
      final_product = {sign, 8'hFF, 23'd0};
    end else if (a_zero || b_zero) begin
      final_product = {sign, 31'd0};
    end else if (exp_sum >= 10'd382) begin
      final_product = {sign, 8'hFF, 23'd0};
    end else if (exp_sum <= 10'd127) begin
      final_product = {sign, 31'd0};
    end else begin
      final_product = {sign, 8'(exp_sum - 10'd127), mant_r[22:0]};
    end
  end

endmodule

module fp_mul_arbiter #(
  parameter int unsigned N   = 4,
  parameter int unsigned IDW = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            enable,
  input  logic [N-1:0]    req_valid,
  output logic [N-1:0]    req_ready,
  input  logic [N*32-1:0] req_a,
  input  logic [N*32-1:0] req_b,
  output logic [N-1:0]    rsp_valid,
  input  logic [N-1:0]    rsp_ready,
  output logic [N*32-1:0] rsp_data,
  output logic [IDW-1:0]  grant_id,
  output logic            busy,
  output logic [15:0]     op_count
);

  logic            op_vld_q;
  logic [31:0]     op_a_q, op_b_q;
  logic [IDW-1:0]  grant_id_q, last_q;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [N*32-1:0] rsp_data_q, rsp_data_d;
  logic [15:0]     op_count_q, fire_cnt;

  logic [N-1:0]    eligible, grant;
  logic [IDW-1:0]  win_idx;
  logic [31:0]     sel_a, sel_b, product;
  logic            found;
  int unsigned     idx;

  fp_multiplier u_mul (
    .num1          (op_a_q),
    .num2          (op_b_q),
    .final_product (product)
  );

  // A requester already in the issue stage or holding a response is not eligible,
  // which guarantees a slot is never overwritten while valid.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      eligible[i] = enable & req_valid[i] & ~rsp_valid_q[i] &
                    ~(op_vld_q && (grant_id_q == IDW'(i)));
    end
  end

  always_comb begin
    grant   = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = 32'(last_q) + k + 1;
      if (idx >= N) idx = idx - N;
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && (i == idx) && eligible[i]) begin
          grant[i] = 1'b1;
          win_idx  = IDW'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < N; i++) begin
      if (grant[i]) begin
        sel_a = sel_a | req_a[i*32 +: 32];
        sel_b = sel_b | req_b[i*32 +: 32];
      end
    end
  end

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    fire_cnt    = '0;
    for (int i = 0; i < N; i++) begin
      if (rsp_valid_q[i] && rsp_ready[i]) begin
        rsp_valid_d[i] = 1'b0;
        fire_cnt       = fire_cnt + 16'd1;
      end
      if (op_vld_q && (grant_id_q == IDW'(i))) begin
        rsp_valid_d[i]         = 1'b1;
        rsp_data_d[i*32 +: 32] = product;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld_q    <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      grant_id_q  <= '0;
      last_q      <= IDW'(N - 1);
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
      op_count_q  <= '0;
    end else begin
      op_vld_q <= |grant;
      if (|grant) begin
        op_a_q     <= sel_a;
        op_b_q     <= sel_b;
        grant_id_q <= win_idx;
        last_q     <= win_idx;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_count_q  <= op_count_q + fire_cnt;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign grant_id  = grant_id_q;
  assign busy      = op_vld_q | (|rsp_valid_q);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_fp_mul_arbiter.sv
// Directed bench for fp_mul_arbiter: single-op vector table plus contention,
// backpressure, enable and mid-operation reset sequences.

module tb_fp_mul_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic [3:0]   req_valid, req_ready, rsp_valid, rsp_ready;
  logic [127:0] req_a, req_b, rsp_data;
  logic [1:0]   grant_id;
  logic         busy;
  logic [15:0]  op_count;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  typedef struct {
    int unsigned idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] p;
  } vec_t;

  vec_t        vecs[9];
  logic [31:0] cont_a[4], cont_b[4], cont_p[4];
  logic [3:0]  bp_seq[6];

  always #5 clk = ~clk;

  fp_mul_arbiter #(.N(4), .IDW(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .grant_id  (grant_id),
    .busy      (busy),
    .op_count  (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_a     = '0;
    req_b     = '0;

    vecs[0] = '{0, 32'h3F800000, 32'h3F800000, 32'h3F800000};
    vecs[1] = '{1, 32'h40000000, 32'h40000000, 32'h40800000};
    vecs[2] = '{2, 32'h41200000, 32'h41200000, 32'h42C80000};
    vecs[3] = '{0, 32'h3FC00000, 32'h3FC00000, 32'h40100000};
    vecs[4] = '{1, 32'h40A00000, 32'h7F800000, 32'h7F800000};
    vecs[5] = '{1, 32'hFF800000, 32'h40A00000, 32'hFF800000};
    vecs[6] = '{2, 32'hC0000000, 32'h40400000, 32'hC0C00000};
    vecs[7] = '{0, 32'h3F800001, 32'h3F800001, 32'h3F800002};
    vecs[8] = '{3, 32'h00000000, 32'h40A00000, 32'h00000000};

    cont_a = '{32'h40000000, 32'h41200000, 32'h3FC00000, 32'h00000000};
    cont_b = '{32'h40000000, 32'h41200000, 32'h3FC00000, 32'h40A00000};
    cont_p = '{32'h40800000, 32'h42C80000, 32'h40100000, 32'h00000000};
    bp_seq = '{4'b1000, 4'b0001, 4'b0010, 4'b1000, 4'b0001, 4'b0010};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'h0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_op_count", 32'(op_count), 32'h0);
    check("rst_grant_id", 32'(grant_id), 32'h0);
    check("rst_rsp_data", 32'(|rsp_data), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single operations, one requester at a time
    for (int v = 0; v < 9; v++) begin
      req_a[vecs[v].idx*32 +: 32] = vecs[v].a;
      req_b[vecs[v].idx*32 +: 32] = vecs[v].b;
      req_valid = 4'(1 << vecs[v].idx);
      @(negedge clk);
      check("vec_req_ready", 32'(req_ready), 32'(1 << vecs[v].idx));
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      check("vec_grant_id", 32'(grant_id), vecs[v].idx);
      check("vec_busy_issue", 32'(busy), 32'h1);
      @(negedge clk);
      check("vec_rsp_valid", 32'(rsp_valid), 32'(1 << vecs[v].idx));
      check("vec_rsp_data", rsp_data[vecs[v].idx*32 +: 32], vecs[v].p);
      rsp_ready = 4'(1 << vecs[v].idx);
      @(posedge clk); #1;
      rsp_ready = '0;
      exp_cnt++;
      @(negedge clk);
      check("vec_op_count", 32'(op_count), 32'(exp_cnt));
      check("vec_busy_idle", 32'(busy), 32'h0);
      @(posedge clk); #1;
    end

    // Contention: all four requesting, two rounds, pointer starts at 3
    for (int i = 0; i < 4; i++) begin
      req_a[i*32 +: 32] = cont_a[i];
      req_b[i*32 +: 32] = cont_b[i];
    end
    rsp_ready = 4'b1111;
    for (int r = 0; r < 2; r++) begin
      req_valid = 4'b1111;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        check("cont_req_ready", 32'(req_ready), (c < 4) ? 32'(1 << c) : 32'h0);
        if (c >= 2) begin
          check("cont_rsp_valid", 32'(rsp_valid), 32'(1 << (c - 2)));
          check("cont_rsp_data", rsp_data[(c-2)*32 +: 32], cont_p[c-2]);
        end
        @(posedge clk); #1;
        if (c < 4) req_valid[c] = 1'b0;
      end
      exp_cnt += 4;
    end
    @(negedge clk);
    check("cont_op_count", 32'(op_count), 32'(exp_cnt));
    check("cont_busy", 32'(busy), 32'h0);

    // Backpressure on requester 2
    @(posedge clk); #1;
    rsp_ready = 4'b1011;
    req_valid = 4'b0100;
    @(negedge clk);
    check("bp_first_grant", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 4'b1111;
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      check("bp_req_ready", 32'(req_ready), 32'(bp_seq[s]));
      if (s >= 1) check("bp_rsp_hold", 32'(rsp_valid[2]), 32'h1);
      if (s == 5) begin
        check("bp_rsp_data", rsp_data[64 +: 32], 32'h40100000);
        rsp_ready = 4'b1111;
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    check("bp_req2_granted", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = '0;
    exp_cnt += 8;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("bp_busy_drain", 32'(busy), 32'h0);
    check("bp_op_count", 32'(op_count), 32'(exp_cnt));

    // enable deasserted with work in flight
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("en_grant3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = 4'b0111;
    enable    = 1'b0;
    @(negedge clk);
    check("en_off_ready_a", 32'(req_ready), 32'h0);
    check("en_off_busy_a", 32'(busy), 32'h1);
    @(negedge clk);
    check("en_off_ready_b", 32'(req_ready), 32'h0);
    check("en_off_busy_b", 32'(busy), 32'h1);
    @(negedge clk);
    check("en_off_ready_c", 32'(req_ready), 32'h0);
    check("en_off_busy_c", 32'(busy), 32'h0);
    @(posedge clk); #1;
    enable = 1'b1;
    @(negedge clk);
    check("en_resume", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;
    exp_cnt += 2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("en_busy_drain", 32'(busy), 32'h0);
    check("en_op_count", 32'(op_count), 32'(exp_cnt));

    // Reset with an op in the issue stage and a pending response in slot 3
    @(posedge clk); #1;
    rsp_ready = '0;
    req_valid = 4'b1000;
    @(negedge clk);
    check("rm_grant3", 32'(req_ready), 32'h8);
    @(posedge clk); #1;
    req_valid = 4'b0001;
    @(negedge clk);
    check("rm_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #2;
    check("rm_pre_rsp_valid", 32'(rsp_valid), 32'h8);
    check("rm_pre_busy", 32'(busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rm_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rm_busy", 32'(busy), 32'h0);
    check("rm_op_count", 32'(op_count), 32'h0);
    check("rm_grant_id", 32'(grant_id), 32'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    req_valid = 4'b1111;
    @(negedge clk);
    check("rm_post_grant0", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = '0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_arbiter.md
Name: fp_mul_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one combinational fp_multiplier (IEEE-754 single precision; ports num1, num2, final_product) among N requesters.
- Registers operands into an issue stage and registers the product into a per-requester response slot.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Sits between the FP compute clients and the single multiplier instance.

Parameters:
- N, 4, number of requesters (2..8).
- IDW, 2, width of grant_id; must be at least ceil(log2(N)).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  when 0, no new grants are issued; in-flight work completes.
- req_valid  in  N  per-requester request valid.
- req_ready  out  N  per-requester accept; one-hot or zero.
- req_a  in  N*32  operand A; requester i uses bits [32i+31:32i].
- req_b  in  N*32  operand B; same packing as req_a.
- rsp_valid  out  N  per-requester result valid.
- rsp_ready  in  N  per-requester result accept.
- rsp_data  out  N*32  per-requester product; same packing as req_a.
- grant_id  out  IDW  index of the requester occupying the issue stage.
- busy  out  1  high when the issue stage or any response slot is occupied.
- op_count  out  16  count of completed response handshakes; wraps at 16 bits.

Behaviour:
- Clock and reset: single clock; rst_n is asynchronous and active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, grant_id=0, busy=0, op_count=0, issue-stage valid op_vld=0, round-robin pointer last=N-1 (requester 0 wins first).
- Eligibility: requester i is eligible when all of the following hold:
  - req_valid[i]=1
  - rsp_valid[i]=0
  - not (op_vld and grant_id==i)
  - enable=1
- One outstanding operation per requester. A response handshake in the same cycle does not free the slot for that cycle.
- Arbitration (combinational):
  - Search eligible requesters starting at (last+1) mod N and ascending with wrap.
  - The first hit w gets req_ready[w]=1; all other req_ready bits are 0.
  - req_ready may depend on req_valid. Requesters must not make req_valid depend on req_ready.
  - Once asserted, req_valid and the operands must hold until the handshake.
- Issue, at the clock edge where req_valid[w] & req_ready[w]:
  - op_a<=req_a[w], op_b<=req_b[w], grant_id<=w, op_vld<=1, last<=w.
  - If there is no handshake, op_vld<=0. grant_id and last hold.
- Execute: fp_multiplier is driven by op_a and op_b. At the edge after issue, if op_vld=1:
  - rsp_data[grant_id]<=final_product.
  - rsp_valid[grant_id]<=1.
- Latency: request handshake at edge k gives rsp_valid visible after edge k+1. Throughput is one operation per cycle across distinct requesters.
- Response:
  - rsp_valid[i] and rsp_data[i] hold until rsp_valid[i] & rsp_ready[i].
  - On that handshake, rsp_valid[i]<=0 and op_count<=op_count+1 (mod 2^16).
  - Responses complete independently, so multiple response handshakes can occur in the same cycle.
  - op_count adds the popcount of the response handshakes in that cycle.
- Simultaneous events:
  - A response write to slot j and a response handshake on a different slot k are both performed.
  - A write to slot j while rsp_valid[j]=1 cannot occur, because the eligibility rule prevents it.
- enable deasserted: req_ready=0 from the same cycle. The issue stage and response slots drain normally.
- Arithmetic: products pass through from fp_multiplier unmodified, including zero, inf and NaN encodings and sign. The arbiter does no rounding and no special-case handling.
- busy = op_vld | (|rsp_valid). It is combinational from registered state.
- Reset mid-operation: all state clears immediately. The in-flight operation and any pending responses are discarded. After release, the pointer is back at N-1.

Test Plan:
- Single op: req0 with a=0x3F800000, b=0x3F800000 accepted at edge k, rsp_ready[0]=1 -> rsp_valid[0]=1 after edge k+1 with rsp_data[0]=0x3F800000; op_count=1 after the response handshake.
- Contention: after reset, all four requesters hold valid simultaneously with ops 2.0x2.0, 10x10, 1.5x1.5, 0x5 -> grants in order 0,1,2,3 on consecutive cycles; rsp_data = 0x40800000, 0x42C80000, 0x40100000, 0x00000000; a second round of requests is again granted 0,1,2,3.
- Backpressure: rsp_ready[2]=0 with requester 2 holding a new request -> req_ready[2] stays 0 and requesters 0, 1 and 3 keep being served; raising rsp_ready[2] -> slot frees, then req2 is granted the following cycle.
- Special values: 5.0 (0x40A00000) x inf (0x7F800000) on req1 -> rsp_data[1] equals fp_multiplier's output bit-exactly; sign check with 0xFF800000 x 0x40A00000 gives the same pass-through result.
- enable: enable=0 with req_valid=4'b1111 -> req_ready=0 and busy falls once in-flight work drains; enable=1 -> grants resume starting at (last+1) mod N.
- Reset mid-op: drop rst_n while op_vld=1 and rsp_valid[3]=1 -> rsp_valid, busy and op_count go to 0 immediately (asynchronously); after release, a request from req0 is granted first.
